// File: rtl/bsg_hb_link_pkg.sv
// Shared definitions for the halfpod IO link credit transmitter and receiver.
// Holds the transmitter state encoding and default credit/decimation constants.
package bsg_hb_link_pkg;

    typedef enum logic [0:0] {
        eINIT,
        eRUN
    } link_tx_state_e;

    localparam int default_credits_lp = 16;
    localparam int default_lg_token_decimation_lp = 2;
    localparam int default_init_cycles_lp = 8;

endpackage

// File: rtl/bsg_hb_link_credit_counter.sv
// Credit counter: decrements per send, adds 2**lg_token_decimation_p per token.
// Ports: clk_i, reset_n_i, dec_i (send), inc_i (accepted token), credits_o, overflow_o (sticky).
module bsg_hb_link_credit_counter
    import bsg_hb_link_pkg::*;
#(
    parameter int credits_p = default_credits_lp,
    parameter int lg_token_decimation_p = default_lg_token_decimation_lp,
    localparam int cw_lp = $clog2(credits_p + 1)
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             dec_i,
    input  logic             inc_i,
    output logic [cw_lp-1:0] credits_o,
    output logic             overflow_o
);

    localparam logic [cw_lp:0] max_lp  = (cw_lp + 1)'(credits_p);
    localparam logic [cw_lp:0] step_lp = (cw_lp + 1)'(2 ** lg_token_decimation_p);

    logic [cw_lp:0] sum;
    logic           over;

    // One extra bit of headroom so a token near the ceiling is seen as overflow.
    always_comb begin
        sum = {1'b0, credits_o};
        if (dec_i) sum = sum - (cw_lp + 1)'(1);
        if (inc_i) sum = sum + step_lp;
        over = (sum > max_lp);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            credits_o  <= cw_lp'(credits_p);
            overflow_o <= 1'b0;
        end else begin
            credits_o  <= over ? cw_lp'(credits_p) : sum[cw_lp-1:0];
            overflow_o <= overflow_o | over;
        end
    end

endmodule

// File: rtl/bsg_hb_link_credit_tx.sv
// Credit-based link lane feeder: 2-entry input buffer, init FSM, registered link output.
// Ports: clk_i, reset_n_i, data_i/v_i/ready_and_o, en_i, link_data_o/link_v_o, token_i,
// credits_o, overflow_o; with BSG_HB_LINK_TX_STATS_EN also sent_count_o, stall_count_o.
module bsg_hb_link_credit_tx
    import bsg_hb_link_pkg::*;
#(
    parameter int width_p = 0,
    parameter int credits_p = default_credits_lp,
    parameter int lg_token_decimation_p = default_lg_token_decimation_lp,
    parameter int init_cycles_p = default_init_cycles_lp,
    localparam int w_lp = (width_p > 0) ? width_p : 1,
    localparam int cw_lp = $clog2(credits_p + 1)
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic [w_lp-1:0]  data_i,
    input  logic             v_i,
    output logic             ready_and_o,
    input  logic             en_i,
    output logic [w_lp-1:0]  link_data_o,
    output logic             link_v_o,
    input  logic             token_i,
    output logic [cw_lp-1:0] credits_o,
`ifdef BSG_HB_LINK_TX_STATS_EN
    output logic [31:0]      sent_count_o,
    output logic [31:0]      stall_count_o,
`endif
    output logic             overflow_o
);

    localparam int iw_lp = (init_cycles_p > 0) ? $clog2(init_cycles_p + 1) : 1;

    link_tx_state_e state_r, state_n;
    logic [iw_lp-1:0] init_cnt_r, init_cnt_n;
    logic init_done;

    assign init_done = (32'(init_cnt_r) + 32'd1) >= 32'(init_cycles_p);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r    <= eINIT;
            init_cnt_r <= '0;
        end else begin
            state_r    <= state_n;
            init_cnt_r <= init_cnt_n;
        end
    end

    always_comb begin
        state_n    = state_r;
        init_cnt_n = init_cnt_r;
        unique case (state_r)
            eINIT: begin
                if (init_done) state_n = eRUN;
                else init_cnt_n = init_cnt_r + 1'b1;
            end
            eRUN: state_n = eRUN;
            default: state_n = eINIT;
        endcase
    end

    logic run;
    assign run = (state_r == eRUN);

    logic [w_lp-1:0] mem_r [2];
    logic wptr_r, rptr_r;
    logic [1:0] cnt_r;
    logic full, empty, enq, send, has_credit;

    assign full        = (cnt_r == 2'd2);
    assign empty       = (cnt_r == 2'd0);
    assign has_credit  = |credits_o;
    assign ready_and_o = run & ~full;
    assign enq         = v_i & ready_and_o;
    assign send        = run & en_i & ~empty & has_credit;

    always_ff @(posedge clk_i) begin
        if (enq) mem_r[wptr_r] <= data_i;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr_r <= 1'b0;
            rptr_r <= 1'b0;
            cnt_r  <= 2'd0;
        end else begin
            if (enq) wptr_r <= ~wptr_r;
            if (send) rptr_r <= ~rptr_r;
            if (enq & ~send) cnt_r <= cnt_r + 2'd1;
            else if (send & ~enq) cnt_r <= cnt_r - 2'd1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            link_v_o    <= 1'b0;
            link_data_o <= '0;
        end else begin
            link_v_o <= send;
            if (send) link_data_o <= mem_r[rptr_r];
        end
    end

    bsg_hb_link_credit_counter #(
        .credits_p(credits_p),
        .lg_token_decimation_p(lg_token_decimation_p)
    ) credit_counter (
        .clk_i(clk_i),
        .reset_n_i(reset_n_i),
        .dec_i(send),
        .inc_i(token_i & run),
        .credits_o(credits_o),
        .overflow_o(overflow_o)
    );

`ifdef BSG_HB_LINK_TX_STATS_EN
    logic stall;
    assign stall = run & en_i & ~empty & ~has_credit;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sent_count_o  <= '0;
            stall_count_o <= '0;
        end else begin
            if (send) sent_count_o <= sent_count_o + 32'd1;
            if (stall) stall_count_o <= stall_count_o + 32'd1;
        end
    end
`endif

endmodule
